// File: rtl/spike_rate_encoder.sv
// spike_rate_encoder: rate-codes per-channel intensities into spike trains
// using one phase accumulator per channel, paced by an external step enable.
module spike_rate_encoder #(
  parameter int NUM_INPUTS      = 4,
  parameter int INTENSITY_WIDTH = 8,
  parameter int NUM_STEPS       = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic [NUM_INPUTS*INTENSITY_WIDTH-1:0] in_data,
  input  logic step_en,
  input  logic abort,
  output logic [NUM_INPUTS-1:0] spike_out,
  output logic spike_valid,
  output logic busy,
  output logic done
);

  localparam int N  = NUM_INPUTS;
  localparam int W  = INTENSITY_WIDTH;
  localparam int CW = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_STEPS - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [W-1:0]  inten [N];
  logic [W-1:0]  acc   [N];
  logic [W:0]    sum   [N];
  logic [N-1:0]  carry;
  logic [CW-1:0] cnt;

  logic accept;
  logic step;
  logic last;
  logic kill;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN);

  assign accept = in_valid & in_ready;
  assign kill   = (state == RUN) & abort;
  assign step   = (state == RUN) & step_en & ~abort;
  assign last   = step & (cnt == LAST);

  // Next-state selection; abort wins over a final step.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (abort)     state_nxt = IDLE;
        else if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Per-channel (W+1)-bit phase sum; the top bit is the spike.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      sum[i]   = {1'b0, acc[i]} + {1'b0, inten[i]};
      carry[i] = sum[i][W];
    end
  end

  // Intensity latch and accumulator update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        inten[i] <= '0;
        acc[i]   <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        inten[i] <= in_data[i*W +: W];
        acc[i]   <= '0;
      end
    end else if (kill) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= sum[i][W-1:0];
      end
    end
  end

  // Step counter within the current window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (accept || kill) cnt <= '0;
    else if (step)           cnt <= cnt + CW'(1);
  end

  // Registered step results; zero on any cycle without a step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spike_out   <= '0;
      spike_valid <= 1'b0;
      done        <= 1'b0;
    end else begin
      spike_out   <= step ? carry : '0;
      spike_valid <= step;
      done        <= last;
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// tb_spike_rate_encoder: table-driven and random windows checked against
// a closed-form spike-timing model, plus reset/abort/handshake sequences.
module tb_spike_rate_encoder;

  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic [N*W-1:0] in_data = '0;
  logic step_en = 1'b0;
  logic abort = 1'b0;

  logic r_a, sv_a, bz_a, dn_a;
  logic [N-1:0] so_a;
  logic r_b, sv_b, bz_b, dn_b;
  logic [N-1:0] so_b;

  logic sel = 1'b0;
  logic rdy, sv, bz, dn;
  logic [N-1:0] so;

  assign rdy = sel ? r_b  : r_a;
  assign sv  = sel ? sv_b : sv_a;
  assign bz  = sel ? bz_b : bz_a;
  assign dn  = sel ? dn_b : dn_a;
  assign so  = sel ? so_b : so_a;

  spike_rate_encoder #(
    .NUM_INPUTS(N), .INTENSITY_WIDTH(W), .NUM_STEPS(256)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r_a), .in_data(in_data),
    .step_en(step_en), .abort(abort),
    .spike_out(so_a), .spike_valid(sv_a),
    .busy(bz_a), .done(dn_a)
  );

  spike_rate_encoder #(
    .NUM_INPUTS(N), .INTENSITY_WIDTH(W), .NUM_STEPS(16)
  ) u_dut16 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(r_b), .in_data(in_data),
    .step_en(step_en), .abort(abort),
    .spike_out(so_b), .spike_valid(sv_b),
    .busy(bz_b), .done(dn_b)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cnt_act [N];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [N*W-1:0] d,
                                         input int k);
    logic [N-1:0] s;
    int i_v;
    for (int c = 0; c < N; c++) begin
      i_v = int'(d[c*W +: W]);
      s[c] = (((k + 1) * i_v) >> W) != ((k * i_v) >> W);
    end
    return s;
  endfunction

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_spike_out", 32'(so_a), 32'h0);
    chk("rst_spike_valid", 32'(sv_a), 32'h0);
    chk("rst_done", 32'(dn_a), 32'h0);
    chk("rst_busy", 32'(bz_a), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(r_a), 32'h1);
    chk("rst_busy_rel", 32'(bz_a), 32'h0);
  endtask

  task automatic load(input logic [N*W-1:0] d);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!rdy && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("load_ready", 32'(rdy), 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("load_busy", 32'(bz), 32'h1);
  endtask

  // Runs one window; abort_at/rst_at < 0 disable those events.
  task automatic run(input logic [N*W-1:0] d, input int ns,
                     input bit toggle, input int abort_at,
                     input int rst_at, input bit hold_new,
                     input logic [N*W-1:0] nd);
    int k, cyc;
    bit se;
    logic [N-1:0] e;
    k = 0;
    cyc = 0;
    for (int c = 0; c < N; c++) cnt_act[c] = 0;
    if (hold_new) begin
      in_valid = 1'b1;
      in_data  = nd;
    end
    while (k < ns) begin
      if (cyc > 4 * ns + 20) begin
        chk("timeout", 32'(k), 32'(ns));
        break;
      end
      se = toggle ? (cyc % 2 == 0) : 1'b1;
      step_en = se;
      abort = (k == abort_at);
      @(negedge clk);
      if (abort) begin
        step_en = 1'b0;
        abort = 1'b0;
        chk("abort_sv", 32'(sv), 32'h0);
        chk("abort_done", 32'(dn), 32'h0);
        chk("abort_busy", 32'(bz), 32'h0);
        chk("abort_ready", 32'(rdy), 32'h1);
        return;
      end
      if (se) begin
        e = model(d, k);
        chk("spike_out", 32'(so), 32'(e));
        chk("spike_valid", 32'(sv), 32'h1);
        chk("done", 32'(dn), 32'(k == ns - 1));
        if (k == ns - 1) chk("ready_at_done", 32'(rdy), 32'h1);
        for (int c = 0; c < N; c++) cnt_act[c] += int'(so[c]);
        k++;
      end else begin
        chk("stall_sv", 32'(sv), 32'h0);
        chk("stall_so", 32'(so), 32'h0);
        chk("stall_done", 32'(dn), 32'h0);
      end
      if (k < ns) begin
        chk("run_busy", 32'(bz), 32'h1);
        chk("run_ready", 32'(rdy), 32'h0);
      end
      if (k == rst_at) begin
        step_en = 1'b0;
        do_reset();
        return;
      end
      cyc++;
    end
    step_en = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_sv", 32'(sv), 32'h0);
    chk("post_done", 32'(dn), 32'h0);
  endtask

  task automatic chk_counts(input logic [N*W-1:0] d, input int ns);
    for (int c = 0; c < N; c++)
      chk($sformatf("count_ch%0d", c), 32'(cnt_act[c]),
          32'((ns * int'(d[c*W +: W])) >> W));
  endtask

  typedef struct {
    logic [N*W-1:0] data;
    bit             toggle;
    int             exp [N];
  } vec_t;

  vec_t tbl [5];
  logic [N*W-1:0] d0, d1;

  initial begin
    tbl[0] = '{ {8'd255, 8'd128, 8'd64, 8'd0}, 1'b0, '{0, 64, 128, 255} };
    tbl[1] = '{ {8'd255, 8'd128, 8'd64, 8'd0}, 1'b1, '{0, 64, 128, 255} };
    tbl[2] = '{ {8'd4, 8'd3, 8'd2, 8'd1}, 1'b0, '{1, 2, 3, 4} };
    tbl[3] = '{ {8'd0, 8'd0, 8'd255, 8'd255}, 1'b0, '{255, 255, 0, 0} };
    tbl[4] = '{ {8'd7, 8'd200, 8'd99, 8'd17}, 1'b1, '{17, 99, 200, 7} };

    #3 rst = 1'b1;
    #1;
    chk("init_so", 32'(so_a), 32'h0);
    chk("init_sv", 32'(sv_a), 32'h0);
    chk("init_busy", 32'(bz_a), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("init_ready", 32'(r_a), 32'h1);

    // step_en in IDLE must not produce results
    step_en = 1'b1;
    @(negedge clk);
    step_en = 1'b0;
    chk("idle_step_sv", 32'(sv_a), 32'h0);

    // reset in the middle of a window
    d0 = {8'd0, 8'd50, 8'd100, 8'd200};
    load(d0);
    run(d0, 256, 1'b0, -1, 10, 1'b0, '0);
    load(d0);
    run(d0, 256, 1'b0, -1, -1, 1'b0, '0);
    chk_counts(d0, 256);

    // table of full windows
    for (int v = 0; v < 5; v++) begin
      load(tbl[v].data);
      run(tbl[v].data, 256, tbl[v].toggle, -1, -1, 1'b0, '0);
      for (int c = 0; c < N; c++)
        chk($sformatf("tbl%0d_ch%0d", v, c), 32'(cnt_act[c]),
            32'(tbl[v].exp[c]));
    end

    // new vector held during RUN; taken right after done
    d0 = {8'd10, 8'd20, 8'd30, 8'd40};
    d1 = {8'd250, 8'd5, 8'd77, 8'd128};
    load(d0);
    run(d0, 256, 1'b0, -1, -1, 1'b1, d1);
    chk_counts(d0, 256);
    chk("b2b_busy", 32'(bz_a), 32'h1);
    run(d1, 256, 1'b0, -1, -1, 1'b0, '0);
    chk_counts(d1, 256);

    // abort together with step_en at step 100, then a fresh window
    d0 = {8'd255, 8'd128, 8'd64, 8'd0};
    load(d0);
    run(d0, 256, 1'b0, 100, -1, 1'b0, '0);
    @(negedge clk);
    chk("abort_no_sv", 32'(sv_a), 32'h0);
    chk("abort_no_done", 32'(dn_a), 32'h0);
    load(d0);
    run(d0, 256, 1'b0, -1, -1, 1'b0, '0);
    chk_counts(d0, 256);

    // abort in IDLE does not block a handshake
    abort = 1'b1;
    load(d0);
    abort = 1'b0;
    run(d0, 256, 1'b0, -1, -1, 1'b0, '0);
    chk_counts(d0, 256);

    // random windows
    for (int r = 0; r < 3; r++) begin
      d0 = $urandom;
      load(d0);
      run(d0, 256, 1'($urandom_range(0, 1)), -1, -1, 1'b0, '0);
      chk_counts(d0, 256);
    end

    // short window instance
    do_reset();
    sel = 1'b1;
    d0 = {8'd128, 8'd128, 8'd128, 8'd128};
    load(d0);
    run(d0, 16, 1'b0, -1, -1, 1'b0, '0);
    chk("w16_ch0", 32'(cnt_act[0]), 32'd8);
    chk("w16_idle", 32'(bz), 32'h0);
    d0 = $urandom;
    load(d0);
    run(d0, 16, 1'b1, -1, -1, 1'b0, '0);
    chk_counts(d0, 16);
    sel = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
